sti_rx: RTL and testbench

- Serial receiver for the STI serial stream (`so_data`/`so_valid`): the far end of the serial transmitter.
- Deserialises each frame (contiguous run of `si_valid`=1 cycles) into a buffer of up to 32 bits, then strips fill/padding and recovers the 16-bit parallel word.
- Presents the word with a one-cycle valid pulse, plus frame-length and padding error flags.
- Used as the loopback checker / downstream deserialiser for the transmitter.

---
 rtl/sti_rx.sv | 186 ++++++++++++++++++
 tb/tb_sti_rx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sti_rx.sv
// sti_rx: serial receiver for the STI stream.
//
// A frame is a contiguous run of si_valid=1 cycles. Each bit lands in a
// 32-bit buffer at a position given by the frame length and bit order.
// When si_valid drops, the receiver strips fill/padding, registers the
// recovered 16-bit word with its error flags, and pulses po_valid for
// one cycle.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   cfg_length  frame length: 0=8, 1=16, 2=24, 3=32 bits
//   cfg_fill    24/32-bit frames: 1=payload in upper 16 bits, 0=lower
//   cfg_msb     1=buffer MSB sent first, 0=LSB first
//   cfg_low     8-bit frames: 1=byte goes to po_data[15:8], 0=[7:0]
//   si_data     serial data bit, sampled when si_valid=1
//   si_valid    bit qualifier; the 1->0 transition ends a frame
//   po_data     recovered word
//   po_valid    one-cycle pulse qualifying po_data/len_err/pad_err
//   len_err     received bit count differed from the expected count
//   pad_err     nonzero padding bit in a 24/32-bit frame
//   frame_cnt   completed frame count, wraps 255->0
//
// Handshake: there is no backpressure. Each si_valid=1 cycle delivers one
// bit; po_valid is asserted for exactly one cycle per completed frame and
// po_data/len_err/pad_err are meaningful only in that cycle.

module sti_rx (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  cfg_length,
    input  logic        cfg_fill,
    input  logic        cfg_msb,
    input  logic        cfg_low,
    input  logic        si_data,
    input  logic        si_valid,
    output logic [15:0] po_data,
    output logic        po_valid,
    output logic        len_err,
    output logic        pad_err,
    output logic [7:0]  frame_cnt
);

    typedef enum logic {IDLE, RECV} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] buf_q, buf_d;
    logic [1:0]  len_q, len_d;
    logic        fill_q, fill_d;
    logic        msb_q, msb_d;
    logic        low_q, low_d;
    logic [15:0] po_data_q, po_data_d;
    logic        po_valid_q, po_valid_d;
    logic        len_err_q, len_err_d;
    logic        pad_err_q, pad_err_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;

    logic [5:0]  e_cur;
    logic [4:0]  idx;
    logic [15:0] word;
    logic        pad;

    // Expected bit count for a length code: 8, 16, 24 or 32.
    function automatic logic [5:0] exp_len(input logic [1:0] l);
        return {1'b0, l, 3'b000} + 6'd8;
    endfunction

    assign e_cur = exp_len(len_q);

    // Payload extraction and padding check from the latched configuration.
    always_comb begin
        word = 16'h0000;
        pad  = 1'b0;
        case (len_q)
            2'd0: word = low_q ? {buf_q[7:0], 8'h00} : {8'h00, buf_q[7:0]};
            2'd1: word = buf_q[15:0];
            2'd2: begin
                if (fill_q) begin
                    word = buf_q[23:8];
                    pad  = |buf_q[7:0];
                end else begin
                    word = buf_q[15:0];
                    pad  = |buf_q[23:16];
                end
            end
            default: begin
                if (fill_q) begin
                    word = buf_q[31:16];
                    pad  = |buf_q[15:0];
                end else begin
                    word = buf_q[15:0];
                    pad  = |buf_q[31:16];
                end
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        len_d       = len_q;
        fill_d      = fill_q;
        msb_d       = msb_q;
        low_d       = low_q;
        po_data_d   = po_data_q;
        po_valid_d  = 1'b0;
        len_err_d   = len_err_q;
        pad_err_d   = pad_err_q;
        frame_cnt_d = frame_cnt_q;
        idx         = 5'd0;

        case (state_q)
            IDLE: begin
                if (si_valid) begin
                    // Configuration is captured only on the first bit.
                    len_d  = cfg_length;
                    fill_d = cfg_fill;
                    msb_d  = cfg_msb;
                    low_d  = cfg_low;
                    idx    = cfg_msb ? 5'(exp_len(cfg_length) - 6'd1) : 5'd0;
                    buf_d  = 32'h0000_0000;
                    buf_d[idx] = si_data;
                    cnt_d  = 6'd1;
                    state_d = RECV;
                end
            end
            default: begin
                if (si_valid) begin
                    if (cnt_q < e_cur) begin
                        idx = msb_q ? 5'(e_cur - 6'd1 - cnt_q) : 5'(cnt_q);
                        buf_d[idx] = si_data;
                    end
                    // Saturate so overlong frames still report len_err.
                    cnt_d = (cnt_q == 6'd33) ? 6'd33 : cnt_q + 6'd1;
                end else begin
                    po_data_d   = word;
                    pad_err_d   = pad;
                    len_err_d   = (cnt_q != e_cur);
                    po_valid_d  = 1'b1;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    cnt_d       = 6'd0;
                    state_d     = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 6'd0;
            buf_q       <= 32'h0000_0000;
            len_q       <= 2'd0;
            fill_q      <= 1'b0;
            msb_q       <= 1'b0;
            low_q       <= 1'b0;
            po_data_q   <= 16'h0000;
            po_valid_q  <= 1'b0;
            len_err_q   <= 1'b0;
            pad_err_q   <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            len_q       <= len_d;
            fill_q      <= fill_d;
            msb_q       <= msb_d;
            low_q       <= low_d;
            po_data_q   <= po_data_d;
            po_valid_q  <= po_valid_d;
            len_err_q   <= len_err_d;
            pad_err_q   <= pad_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign po_data   = po_data_q;
    assign po_valid  = po_valid_q;
    assign len_err   = len_err_q;
    assign pad_err   = pad_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sti_rx.sv
// Directed testbench for sti_rx. Inputs change 1 time unit after each
// rising edge; outputs are sampled at that same point.

module tb_sti_rx;

    logic        clk;
    logic        reset;
    logic [1:0]  cfg_length;
    logic        cfg_fill;
    logic        cfg_msb;
    logic        cfg_low;
    logic        si_data;
    logic        si_valid;
    logic [15:0] po_data;
    logic        po_valid;
    logic        len_err;
    logic        pad_err;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    sti_rx dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_length (cfg_length),
        .cfg_fill   (cfg_fill),
        .cfg_msb    (cfg_msb),
        .cfg_low    (cfg_low),
        .si_data    (si_data),
        .si_valid   (si_valid),
        .po_data    (po_data),
        .po_valid   (po_valid),
        .len_err    (len_err),
        .pad_err    (pad_err),
        .frame_cnt  (frame_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (po_valid) pulse_cnt++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        si_valid = 1'b0;
        si_data = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Sends bits[n-1] first, down to bits[0], then one si_valid=0 gap cycle.
    // When toggle is set, cfg_msb flips on every bit after the first.
    task automatic send_bits(input logic [39:0] bits, input int n, input bit toggle);
        logic msb_keep;
        msb_keep = cfg_msb;
        for (int k = 0; k < n; k++) begin
            si_valid = 1'b1;
            si_data  = bits[n-1-k];
            tick();
            if (toggle) cfg_msb = ~cfg_msb;
        end
        cfg_msb  = msb_keep;
        si_valid = 1'b0;
        si_data  = 1'b0;
        tick();
    endtask

    // Checks the frame-end outputs, then that po_valid drops next cycle.
    task automatic check_frame(input string tag, input logic [15:0] exp_data,
                               input logic exp_len, input logic exp_pad,
                               input logic [7:0] exp_cnt);
        check({tag, "_valid"}, 32'(po_valid), 32'd1);
        check({tag, "_data"},  32'(po_data),  32'(exp_data));
        check({tag, "_len"},   32'(len_err),  32'(exp_len));
        check({tag, "_pad"},   32'(pad_err),  32'(exp_pad));
        check({tag, "_cnt"},   32'(frame_cnt), 32'(exp_cnt));
        tick();
        check({tag, "_drop"},  32'(po_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        cfg_length = 2'd0;
        cfg_fill = 1'b0;
        cfg_msb = 1'b0;
        cfg_low = 1'b0;
        si_data = 1'b0;
        si_valid = 1'b0;

        do_reset();
        check("rst_valid", 32'(po_valid), 32'd0);
        check("rst_data",  32'(po_data),  32'd0);
        check("rst_len",   32'(len_err),  32'd0);
        check("rst_pad",   32'(pad_err),  32'd0);
        check("rst_cnt",   32'(frame_cnt), 32'd0);

        // 16-bit, MSB first; po_valid must be low during the last bit.
        cfg_length = 2'd1; cfg_msb = 1'b1;
        pulse_cnt = 0;
        send_bits(40'hA5C3, 16, 1'b0);
        check_frame("f16", 16'hA5C3, 1'b0, 1'b0, 8'd1);
        check("f16_one_pulse", 32'(pulse_cnt), 32'd1);

        // 8-bit, LSB first, bits in time order 0,1,0,1,1,0,1,0.
        cfg_length = 2'd0; cfg_msb = 1'b0; cfg_low = 1'b1;
        send_bits(40'h5A, 8, 1'b0);
        check_frame("f8_hi", 16'h5A00, 1'b0, 1'b0, 8'd2);
        cfg_low = 1'b0;
        send_bits(40'h5A, 8, 1'b0);
        check_frame("f8_lo", 16'h005A, 1'b0, 1'b0, 8'd3);

        // 32-bit, fill=1: payload in upper half, clean padding.
        cfg_length = 2'd3; cfg_fill = 1'b1; cfg_msb = 1'b1;
        send_bits(40'h1234_0000, 32, 1'b0);
        check_frame("f32", 16'h1234, 1'b0, 1'b0, 8'd4);

        // 24-bit, fill=0: pad byte 8'h80 first, then BEEF.
        cfg_length = 2'd2; cfg_fill = 1'b0;
        send_bits(40'h80_BEEF, 24, 1'b0);
        check_frame("f24", 16'hBEEF, 1'b0, 1'b1, 8'd5);

        // Short 16-bit frame: 12 bits, missing bits read as 0.
        cfg_length = 2'd1;
        send_bits(40'hABC, 12, 1'b0);
        check_frame("short", 16'hABC0, 1'b1, 1'b0, 8'd6);

        // Long 16-bit frame: 20 bits, first 16 kept.
        send_bits(40'h12345, 20, 1'b0);
        check_frame("long", 16'h1234, 1'b1, 1'b0, 8'd7);

        // 1-bit frame on an 8-bit config, MSB first -> buf[7].
        cfg_length = 2'd0; cfg_low = 1'b0;
        send_bits(40'h1, 1, 1'b0);
        check_frame("one_bit", 16'h0080, 1'b1, 1'b0, 8'd8);

        // 256 back-to-back 8-bit frames, single gap cycles, msb toggled
        // mid-frame; frame_cnt returns to 0.
        do_reset();
        cfg_length = 2'd0; cfg_msb = 1'b1; cfg_low = 1'b0;
        pulse_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            send_bits(40'(i), 8, 1'b1);
            check("b2b_valid", 32'(po_valid), 32'd1);
            check("b2b_data", 32'(po_data), 32'(i));
            check("b2b_cnt", 32'(frame_cnt), 32'((i + 1) % 256));
        end
        tick();
        check("b2b_drop", 32'(po_valid), 32'd0);
        check("b2b_pulses", 32'(pulse_cnt), 32'd256);
        check("b2b_wrap", 32'(frame_cnt), 32'd0);

        // Reset at bit 5 of a 32-bit frame: no pulse afterwards.
        cfg_length = 2'd3; cfg_fill = 1'b1; cfg_msb = 1'b1;
        for (int k = 0; k < 5; k++) begin
            si_valid = 1'b1;
            si_data = 1'b1;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        si_valid = 1'b0;
        si_data = 1'b0;
        pulse_cnt = 0;
        for (int k = 0; k < 4; k++) tick();
        check("mid_rst_pulses", 32'(pulse_cnt), 32'd0);
        check("mid_rst_data", 32'(po_data), 32'd0);
        check("mid_rst_len", 32'(len_err), 32'd0);
        check("mid_rst_pad", 32'(pad_err), 32'd0);
        check("mid_rst_cnt", 32'(frame_cnt), 32'd0);

        cfg_length = 2'd1;
        send_bits(40'hC35A, 16, 1'b0);
        check_frame("after_rst", 16'hC35A, 1'b0, 1'b0, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
